// File: rtl/readout_sequencer_if.sv
// Handshake bundle between the readout sequencer, the SPI command master and the readout block.
// master = sequencer side, slave = SPI/readout side.
interface readout_sequencer_if;
  logic spi_req;
  logic spi_ack;
  logic fifo_afull;
  logic readout_start;
  logic readout_active;

  modport master (
    output spi_req, readout_start,
    input  spi_ack, fifo_afull, readout_active
  );

  modport slave (
    input  spi_req, readout_start,
    output spi_ack, fifo_afull, readout_active
  );
endinterface

// File: rtl/readout_sequencer.sv
// One chip acquisition cycle: trigger, SPI readout command, FIFO gate, readout, chip reset.
// Waits in WAIT_TRIG/SPI/READ are bounded; a timeout sets a sticky err bit and resets the chip.
module readout_sequencer #(
  parameter int TRIG_LEN = 4,
  parameter int RST_LEN  = 8,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 sw_trig,
  input  logic                 trig_from_chip,
  readout_sequencer_if.master  bus,
  output logic                 trig_to_chip,
  output logic                 chip_rst,
  output logic                 busy,
  output logic [2:0]           state_o,
  output logic [CNT_W-1:0]     event_count,
  output logic [2:0]           err,
  input  logic                 err_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_SPI       = 3'd3,
    S_WAIT_FIFO = 3'd4,
    S_START     = 3'd5,
    S_READ      = 3'd6,
    S_CHIPRST   = 3'd7
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       err_q;
  logic [CNT_W-1:0] count_q;
  logic             trig_q, chip_rst_q, spi_req_q, start_q;
  logic             edge_latch_q, active_seen_q;
  logic             sync1_q, sync2_q, hist_q;
  logic             trig_edge, tmo;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= trig_from_chip;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign trig_edge = sync2_q & ~hist_q;
  // Shared counter: pulse length in TRIG/CHIPRST, wait time in WAIT_TRIG/SPI/READ.
  assign tmo       = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      err_q         <= '0;
      count_q       <= '0;
      trig_q        <= 1'b0;
      chip_rst_q    <= 1'b0;
      spi_req_q     <= 1'b0;
      start_q       <= 1'b0;
      edge_latch_q  <= 1'b0;
      active_seen_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      cnt_q   <= cnt_q + 1'b1;
      if (err_clr) err_q <= '0;
      case (state_q)
        S_IDLE: begin
          cnt_q         <= '0;
          edge_latch_q  <= 1'b0;
          active_seen_q <= 1'b0;
          if (sw_trig) begin
            state_q <= S_TRIG;
            trig_q  <= 1'b1;
          end else if (enable && trig_edge) begin
            state_q   <= S_SPI;
            spi_req_q <= 1'b1;
          end
        end
        S_TRIG: begin
          if (trig_edge) edge_latch_q <= 1'b1;
          if (cnt_q == CW'(TRIG_LEN - 1)) begin
            trig_q  <= 1'b0;
            state_q <= S_WAIT_TRIG;
            cnt_q   <= '0;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_edge || edge_latch_q) begin
            state_q   <= S_SPI;
            spi_req_q <= 1'b1;
            cnt_q     <= '0;
          end else if (tmo) begin
            state_q    <= S_CHIPRST;
            chip_rst_q <= 1'b1;
            cnt_q      <= '0;
            err_q      <= (err_clr ? 3'b000 : err_q) | 3'b001;
          end
        end
        S_SPI: begin
          if (bus.spi_ack) begin
            state_q   <= S_WAIT_FIFO;
            spi_req_q <= 1'b0;
          end else if (tmo) begin
            state_q    <= S_CHIPRST;
            spi_req_q  <= 1'b0;
            chip_rst_q <= 1'b1;
            cnt_q      <= '0;
            err_q      <= (err_clr ? 3'b000 : err_q) | 3'b010;
          end
        end
        S_WAIT_FIFO: begin
          if (!bus.fifo_afull) begin
            state_q <= S_START;
            start_q <= 1'b1;
          end
        end
        S_START: begin
          state_q       <= S_READ;
          cnt_q         <= '0;
          active_seen_q <= 1'b0;
        end
        S_READ: begin
          if (bus.readout_active) active_seen_q <= 1'b1;
          if (active_seen_q && !bus.readout_active) begin
            state_q    <= S_CHIPRST;
            chip_rst_q <= 1'b1;
            cnt_q      <= '0;
            count_q    <= count_q + 1'b1;
          end else if (tmo) begin
            state_q    <= S_CHIPRST;
            chip_rst_q <= 1'b1;
            cnt_q      <= '0;
            err_q      <= (err_clr ? 3'b000 : err_q) | 3'b100;
          end
        end
        S_CHIPRST: begin
          if (cnt_q == CW'(RST_LEN - 1)) begin
            chip_rst_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.spi_req       = spi_req_q;
  assign bus.readout_start = start_q;
  assign trig_to_chip      = trig_q;
  assign chip_rst          = chip_rst_q;
  assign busy              = (state_q != S_IDLE);
  assign state_o           = state_q;
  assign event_count       = count_q;
  assign err               = err_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed and randomized acquisitions checked against an outcome-level model of the sequencer
// (pulse lengths, pulse counts, event count and sticky error bits per acquisition).
module tb_readout_sequencer;
  localparam int TRIG_LEN = 4;
  localparam int RST_LEN  = 8;
  localparam int TIMEOUT  = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        sw_trig = 1'b0;
  logic        trig_from_chip = 1'b0;
  logic        err_clr = 1'b0;
  logic        trig_to_chip, chip_rst, busy;
  logic [2:0]  state_o, err;
  logic [15:0] event_count;

  readout_sequencer_if bus ();

  always #5 clk = ~clk;

  readout_sequencer #(
    .TRIG_LEN(TRIG_LEN), .RST_LEN(RST_LEN), .TIMEOUT(TIMEOUT), .CNT_W(16)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .sw_trig(sw_trig),
    .trig_from_chip(trig_from_chip), .bus(bus), .trig_to_chip(trig_to_chip),
    .chip_rst(chip_rst), .busy(busy), .state_o(state_o), .event_count(event_count),
    .err(err), .err_clr(err_clr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: acquisitions completed and accumulated error flags.
  int         exp_count = 0;
  logic [2:0] exp_err   = 3'b000;

  // Output monitors: cumulative high-cycle totals, pulse counts and last run lengths.
  int trig_total = 0, rst_total = 0, start_total = 0, spi_total = 0;
  int trig_run = 0, rst_run = 0, trig_last = 0, rst_last = 0;

  always @(posedge clk) begin
    trig_total  <= trig_total + int'(trig_to_chip);
    rst_total   <= rst_total + int'(chip_rst);
    start_total <= start_total + int'(bus.readout_start);
    spi_total   <= spi_total + int'(bus.spi_req);
    trig_run    <= trig_to_chip ? trig_run + 1 : 0;
    rst_run     <= chip_rst ? rst_run + 1 : 0;
    if (!trig_to_chip && trig_run != 0) trig_last <= trig_run;
    if (!chip_rst && rst_run != 0) rst_last <= rst_run;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 spi_req high, 1 readout_start high, 2 chip_rst high, 3 busy low
  task automatic wait_until(input int which, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      case (which)
        0: ok = (bus.spi_req === 1'b1);
        1: ok = (bus.readout_start === 1'b1);
        2: ok = (chip_rst === 1'b1);
        3: ok = (busy === 1'b0);
        default: ok = 1'b0;
      endcase
      if (!ok) tick();
    end
    check(tag, {31'd0, ok}, 1);
  endtask

  task automatic chip_pulse();
    trig_from_chip = 1'b1;
    tick(); tick(); tick();
    trig_from_chip = 1'b0;
  endtask

  // mode: 0 normal, 1 spi_ack never arrives, 2 readout_active stuck high
  task automatic run_acq(input bit use_sw, input int edge_dly, input int ack_dly,
                         input int afull_dly, input int active_len, input int mode,
                         input bit edge_in_rst);
    int t0, r0, s0, p0;
    t0 = trig_total; r0 = rst_total; s0 = start_total; p0 = spi_total;
    if (use_sw) begin
      enable  = 1'b0;
      sw_trig = 1'b1;
      tick();
      sw_trig = 1'b0;
      repeat (edge_dly) tick();
    end else begin
      enable = 1'b1;
    end
    chip_pulse();
    wait_until(0, 40, "spi_req_rise");
    if (mode == 1) begin
      // err_clr held across the timeout: the new error must win that cycle
      err_clr = 1'b1;
      wait_until(2, TIMEOUT + 20, "spi_timeout_chip_rst");
      exp_err = 3'b010;
      check("err_set_wins_over_clr", err, exp_err);
      check("spi_req_dropped_on_tmo", bus.spi_req, 0);
      err_clr = 1'b0;
    end else begin
      bus.fifo_afull = (afull_dly > 0);
      repeat (ack_dly) tick();
      bus.spi_ack = 1'b1;
      check("spi_req_during_ack", bus.spi_req, 1);
      tick();
      bus.spi_ack = 1'b0;
      check("spi_req_drop_after_ack", bus.spi_req, 0);
      check("spi_req_high_len_ok", {31'd0, (spi_total - p0) >= ack_dly + 1}, 1);
      if (afull_dly > 0) begin
        repeat (afull_dly) tick();
        check("no_start_while_afull", start_total - s0, 0);
        bus.fifo_afull = 1'b0;
      end
      wait_until(1, 10, "readout_start_pulse");
      tick(); tick();
      bus.readout_active = 1'b1;
      if (mode == 2) begin
        wait_until(2, TIMEOUT + 20, "read_timeout_chip_rst");
        exp_err = exp_err | 3'b100;
        bus.readout_active = 1'b0;
      end else begin
        repeat (active_len) tick();
        bus.readout_active = 1'b0;
        exp_count++;
        wait_until(2, 10, "chip_rst_after_read");
      end
    end
    if (edge_in_rst) chip_pulse();
    wait_until(3, RST_LEN + 10, "return_idle");
    repeat (4) tick();
    enable = 1'b0;
    check("idle_stays_idle", state_o, 0);
    check("trig_cycles", trig_total - t0, use_sw ? TRIG_LEN : 0);
    if (use_sw) check("trig_run_len", trig_last, TRIG_LEN);
    check("chip_rst_cycles", rst_total - r0, RST_LEN);
    check("chip_rst_run_len", rst_last, RST_LEN);
    check("readout_start_count", start_total - s0, (mode == 1) ? 0 : 1);
    check("event_count", event_count, exp_count % 65536);
    check("err", err, exp_err);
    $display("acq sw=%0d edge=%0d ack=%0d afull=%0d active=%0d mode=%0d count=%0d err=%b",
             use_sw, edge_dly, ack_dly, afull_dly, active_len, mode, event_count, err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trig"}, trig_to_chip, 0);
    check({tag, "_chip_rst"}, chip_rst, 0);
    check({tag, "_spi_req"}, bus.spi_req, 0);
    check({tag, "_start"}, bus.readout_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_count"}, event_count, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    bus.spi_ack        = 1'b0;
    bus.fifo_afull     = 1'b0;
    bus.readout_active = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (3) tick();

    run_acq(1'b1, 10, 20, 0, 1280, 0, 1'b0);
    run_acq(1'b0, 0, 5, 0, 50, 0, 1'b0);
    run_acq(1'b1, 3, 7, 500, 40, 0, 1'b0);
    run_acq(1'b0, 0, 3, 0, 20, 0, 1'b1);
    run_acq(1'b1, 5, 0, 0, 0, 1, 1'b0);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 3'b000;
    check("err_clr_after_spi_tmo", err, exp_err);

    run_acq(1'b0, 0, 4, 0, 0, 2, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 3'b000;
    check("err_clr_after_read_tmo", err, exp_err);
    check("count_after_tmos", event_count, exp_count);

    run_acq(1'b1, 1, 2, 0, 10, 0, 1'b0);

    // Asynchronous reset in the middle of a readout transfer
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    chip_pulse();
    wait_until(0, 40, "mid_spi_req_rise");
    bus.spi_ack = 1'b1;
    tick();
    bus.spi_ack = 1'b0;
    wait_until(1, 10, "mid_readout_start");
    tick();
    bus.readout_active = 1'b1;
    repeat (10) tick();
    check("mid_read_state", state_o, 6);
    check("mid_read_count", event_count, 5);
    #2 rstn = 1'b0;
    #1;
    exp_count = 0;
    exp_err   = 3'b000;
    check_all_zero("async_rst");
    bus.readout_active = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    repeat (3) tick();
    $display("async reset mid-read count=%0d state=%0d", event_count, state_o);
    run_acq(1'b1, 6, 9, 0, 30, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      bit use_sw;
      int afull;
      use_sw = 1'($urandom_range(0, 1));
      afull  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0;
      run_acq(use_sw, int'($urandom_range(1, 15)), int'($urandom_range(0, 40)), afull,
              int'($urandom_range(1, 200)), 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
